// File: rtl/u_counter.sv
// ---------------------------------------------------------------------------
// u_counter -- free-running binary up-counter with synchronous parallel load.
//
// Counts up by one on every rising edge of clk and wraps modulo 2^WIDTH.
// A load strobe replaces the increment with a parallel preset value for that
// edge. The count output comes straight from a register, so it has no
// combinational path from any input.
//
// Parameters:
//   WIDTH        counter / load bus width, 2..32
//   RESET_VALUE  value held on binary while reset is high (truncated to WIDTH)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   load_s  in   synchronous load strobe; takes priority over counting
//   load    in   parallel preset value, sampled when load_s=1
//   binary  out  registered count
//   tc      out  registered terminal-count flag (binary == all-ones);
//                present only when U_COUNTER_TC_EN is defined
//
// Build option:
//   U_COUNTER_TC_EN  adds the tc output and its register.
// ---------------------------------------------------------------------------
module u_counter #(
    parameter int          WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_s,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] binary
`ifdef U_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

    // Value binary takes on the next edge: load wins over increment, and the
    // add simply overflows past all-ones back to zero.
    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = binary + WIDTH'(1);
        if (load_s)
            nxt = load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            binary <= RST_V;
        else
            binary <= nxt;
    end

`ifdef U_COUNTER_TC_EN
    // tc is registered from the same next-value as binary, so both update on
    // the same edge and tc never glitches. Under reset it reflects whether
    // the reset value itself is terminal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tc <= (RST_V == {WIDTH{1'b1}});
        else
            tc <= (nxt == {WIDTH{1'b1}});
    end
`endif

endmodule

// File: tb/tb_u_counter.sv
// ---------------------------------------------------------------------------
// tb_u_counter -- scoreboard bench for u_counter (WIDTH=4, RESET_VALUE=0).
// The stimulus process drives inputs on the falling edge and pushes the
// value the count must hold after the next rising edge; a monitor pops and
// compares just after every rising edge. Immediate async-reset effects are
// checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_u_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;
    localparam int RV  = 0;

    typedef struct {
        int  bin;
        bit  tcv;
        int  id;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_s = 1'b0;
    logic [W-1:0] load = '0;
    logic [W-1:0] binary;
`ifdef U_COUNTER_TC_EN
    logic         tc;
`endif

    int   tests = 0;
    int   fails = 0;
    int   model = RV;     // reference count, plain integer arithmetic
    int   step_id = 0;
    exp_t sb[$];

    u_counter #(.WIDTH(W), .RESET_VALUE(32'(RV))) dut (
        .clk    (clk),
        .reset  (reset),
        .load_s (load_s),
        .load   (load),
        .binary (binary)
`ifdef U_COUNTER_TC_EN
        ,
        .tc     (tc)
`endif
    );

    always #5 clk = ~clk;

    // Apply inputs for one edge, predict the result, wait through the edge.
    task automatic step(input bit ls, input int ld);
        exp_t e;
        load_s = ls;
        load   = W'(ld);
        if (reset)
            model = RV;
        else if (ls)
            model = ld % MOD;
        else
            model = (model + 1) % MOD;
        e.bin = model;
        e.tcv = (model == MOD - 1);
        e.id  = step_id;
        step_id++;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_now(input string name, input int want);
        tests++;
        if (int'(binary) != want) begin
            fails++;
            $display("FAIL %s: binary=%0d expected=%0d at %0t", name, binary, want, $time);
        end
    endtask

    // Monitor: one expected entry per rising edge issued by the stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (int'(binary) != e.bin) begin
                    fails++;
                    $display("FAIL step%0d binary: got=%0d expected=%0d", e.id, binary, e.bin);
                end
`ifdef U_COUNTER_TC_EN
                tests++;
                if (tc != e.tcv) begin
                    fails++;
                    $display("FAIL step%0d tc: got=%0b expected=%0b", e.id, tc, e.tcv);
                end
`endif
            end
        end
    end

    initial begin
        // Reset then free count: reset visible without a clock edge.
        #1;
        check_now("reset_async", RV);
        #1;
        reset = 1'b0;
        model = RV;
        // Wrap: 1..15 then 0 over 16 edges.
        for (int i = 0; i < 16; i++) step(1'b0, 0);

        // Load: from 3, load 10, then 11, 12.
        for (int i = 0; i < 3; i++) step(1'b0, 0);
        step(1'b1, 10);
        step(1'b0, 0);
        step(1'b0, 0);

        // Load held for 3 edges, then count to 6.
        for (int i = 0; i < 3; i++) step(1'b1, 5);
        step(1'b0, 0);

        // Load all-ones then wrap.
        step(1'b1, 15);
        step(1'b0, 0);

        // Async reset mid-count at 9.
        step(1'b1, 8);
        step(1'b0, 0);
        reset = 1'b1;
        #1;
        check_now("reset_midcount", RV);
        step(1'b0, 0);
        step(1'b1, 3);
        // Reset vs load collision.
        step(1'b1, 7);
        reset = 1'b0;
        model = RV;
        step(1'b0, 0);
        step(1'b0, 0);

        // Randomised traffic, with occasional resets that win over loads.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                reset = 1'b1;
                #1;
                check_now("reset_rand", RV);
                step($urandom_range(0, 1) == 1, int'($urandom_range(0, MOD - 1)));
                reset = 1'b0;
            end else if (r < 34) begin
                step(1'b1, int'($urandom_range(0, MOD - 1)));
            end else begin
                step(1'b0, 0);
            end
        end

        // Drain: the monitor must have consumed everything within a few edges.
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
